// File: rtl/trail_engine_if.sv
// rtl/trail_engine_if.sv - sprite ROM read port and frame-buffer write port bundle
//
// Purpose: groups the engine's memory-side handshake signals.
// Ports (modport master = engine side, slave = memory side):
//   rom_code  engine -> ROM  sprite select
//   rom_pix   engine -> ROM  pixel index inside the sprite, row-major
//   rom_data  ROM -> engine  sprite pixel, valid one cycle after code/pix
//   fb_addr   engine -> FB   write address
//   fb_data   engine -> FB   write data
//   fb_we     engine -> FB   write request
//   fb_ready  FB -> engine   write accepted this cycle
interface trail_engine_if #(
   parameter int CODE_W = 3,
   parameter int PIX_W  = 6,
   parameter int FB_AW  = 20
);
   logic [CODE_W-1:0] rom_code;
   logic [PIX_W-1:0]  rom_pix;
   logic [15:0]       rom_data;
   logic [FB_AW-1:0]  fb_addr;
   logic [15:0]       fb_data;
   logic              fb_we;
   logic              fb_ready;

   modport master (
      output rom_code, rom_pix, fb_addr, fb_data, fb_we,
      input  rom_data, fb_ready
   );

   modport slave (
      input  rom_code, rom_pix, fb_addr, fb_data, fb_we,
      output rom_data, fb_ready
   );
endinterface

// File: rtl/trail_engine.sv
// rtl/trail_engine.sv - trail recorder and tile renderer for light-cycles
//
// Purpose: records every cell each player enters in an occupancy grid, flags
// collisions with occupied or out-of-bounds cells, and copies a TILE x TILE
// sprite from the sprite ROM into the frame buffer for every new cell.
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Game_State          global game state; PLAY_STATE enables recording
//   pos_x, pos_y, dir   packed per-player cell position and direction
//   bus (master)        sprite ROM read port and frame-buffer write port
//   collision           sticky per-player collision flags
//   overflow            sticky per-player lost-move flags
//   busy                engine is not idle
// Optional feature macro: COLLIDE_FREEZE_EN (crashed players stop moving
// until the next entry into PLAY_STATE).
module trail_engine #(
   parameter int          NUM_PLAYERS = 2,
   parameter int          COORD_W     = 8,
   parameter int          GRID_W      = 56,
   parameter int          GRID_H      = 56,
   parameter int          TILE        = 8,
   parameter int          FB_W        = 640,
   parameter int          ORIGIN_X    = 14,
   parameter int          ORIGIN_Y    = 14,
   parameter int          FB_AW       = 20,
   parameter logic [2:0]  PLAY_STATE  = 3'b010
) (
   input  logic                           Clk,
   input  logic                           Reset_n,
   input  logic [2:0]                     Game_State,
   input  logic [NUM_PLAYERS*COORD_W-1:0] pos_x,
   input  logic [NUM_PLAYERS*COORD_W-1:0] pos_y,
   input  logic [NUM_PLAYERS*2-1:0]       dir,
   trail_engine_if.master                 bus,
   output logic [NUM_PLAYERS-1:0]         collision,
   output logic [NUM_PLAYERS-1:0]         overflow,
   output logic                           busy
);

   localparam int CODE_W = $clog2(2*NUM_PLAYERS+2);
   localparam int NPIX   = TILE*TILE;
   localparam int PIX_W  = $clog2(NPIX);
   localparam int CELLS  = GRID_W*GRID_H;
   localparam int GIDX_W = $clog2(CELLS);
   localparam int PW     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam logic [CODE_W-1:0] CORNER = CODE_W'(2*NUM_PLAYERS+1);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_MARK, S_DRAW_RD, S_DRAW_WR, S_CLEAR
   } state_t;

   // ---------------- per-player move capture ----------------
   logic                 play, play_q, entry;
   logic [NUM_PLAYERS-1:0] pending;
   logic [NUM_PLAYERS-1:0] pos_chg, moved;
   logic [COORD_W-1:0]   in_x   [NUM_PLAYERS];
   logic [COORD_W-1:0]   in_y   [NUM_PLAYERS];
   logic [1:0]           in_d   [NUM_PLAYERS];
   logic [CODE_W-1:0]    new_code [NUM_PLAYERS];
   logic [COORD_W-1:0]   old_x  [NUM_PLAYERS];
   logic [COORD_W-1:0]   old_y  [NUM_PLAYERS];
   logic [1:0]           old_d  [NUM_PLAYERS];
   logic [COORD_W-1:0]   lat_x  [NUM_PLAYERS];
   logic [COORD_W-1:0]   lat_y  [NUM_PLAYERS];
   logic [CODE_W-1:0]    lat_code [NUM_PLAYERS];

   // FSM-to-player-state strobes
   logic                 done;
   logic                 set_coll;

   // ---------------- FSM state ----------------
   state_t               state, state_n;
   logic [PW-1:0]        cur, cur_n, rr_ptr, rr_n, sel, next_rr;
   logic                 sel_found;
   logic [PIX_W-1:0]     pix, pix_n;
   logic [GIDX_W-1:0]    clr_idx, clr_n;
   logic [15:0]          data_q, data_n;
   logic                 wr_held, wr_held_n;

   // ---------------- grid RAM ----------------
   logic [CODE_W-1:0]    grid [CELLS];
   logic [CODE_W-1:0]    rd_data;
   logic                 rd_en, gr_we;
   logic [GIDX_W-1:0]    gr_waddr, cell_idx;
   logic [CODE_W-1:0]    gr_wdata;
   logic                 oob;

   // ---------------- outputs ----------------
   logic [CODE_W-1:0]    rom_code_o;
   logic [PIX_W-1:0]     rom_pix_o;
   logic [FB_AW-1:0]     fb_addr_o;
   logic [15:0]          fb_data_o;
   logic                 fb_we_o;
   int                   px_x, px_y;

   assign play  = (Game_State == PLAY_STATE);
   assign entry = play & ~play_q;
   assign busy  = (state != S_IDLE);

   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         in_x[p]    = pos_x[p*COORD_W +: COORD_W];
         in_y[p]    = pos_y[p*COORD_W +: COORD_W];
         in_d[p]    = dir[p*2 +: 2];
         pos_chg[p] = play && !entry && ((in_x[p] != old_x[p]) || (in_y[p] != old_y[p]));
`ifdef COLLIDE_FREEZE_EN
         moved[p]   = pos_chg[p] && !collision[p];
`else
         moved[p]   = pos_chg[p];
`endif
         // dir[1] set means left/right, i.e. a horizontal segment
         if (in_d[p] != old_d[p])
            new_code[p] = CORNER;
         else if (in_d[p][1])
            new_code[p] = CODE_W'(1 + 2*p);
         else
            new_code[p] = CODE_W'(2 + 2*p);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         play_q    <= 1'b0;
         pending   <= '0;
         collision <= '0;
         overflow  <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            old_x[p]    <= '0;
            old_y[p]    <= '0;
            old_d[p]    <= '0;
            lat_x[p]    <= '0;
            lat_y[p]    <= '0;
            lat_code[p] <= '0;
         end
      end else begin
         play_q <= play;
         if (entry) begin
            // new round: forget flags, adopt current positions silently
            pending   <= '0;
            collision <= '0;
            overflow  <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
               old_x[p] <= in_x[p];
               old_y[p] <= in_y[p];
               old_d[p] <= in_d[p];
            end
         end else begin
            if (done)
               pending[cur] <= 1'b0;
            if (set_coll)
               collision[cur] <= 1'b1;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
               if (pos_chg[p]) begin
                  old_x[p] <= in_x[p];
                  old_y[p] <= in_y[p];
                  old_d[p] <= in_d[p];
               end
               if (moved[p]) begin
                  if (pending[p]) begin
                     overflow[p] <= 1'b1;
                  end else begin
                     pending[p]  <= 1'b1;
                     lat_x[p]    <= in_x[p];
                     lat_y[p]    <= in_y[p];
                     lat_code[p] <= new_code[p];
                  end
               end
            end
         end
      end
   end

   // round-robin pick: first pending player at or after rr_ptr
   always_comb begin
      sel_found = 1'b0;
      sel       = rr_ptr;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (!sel_found && pending[PW'((int'(rr_ptr) + i) % NUM_PLAYERS)]) begin
            sel_found = 1'b1;
            sel       = PW'((int'(rr_ptr) + i) % NUM_PLAYERS);
         end
      end
   end

   assign next_rr  = (int'(cur) == NUM_PLAYERS-1) ? '0 : cur + 1'b1;
   assign oob      = (int'(lat_x[cur]) >= GRID_W) || (int'(lat_y[cur]) >= GRID_H);
   assign cell_idx = GIDX_W'(int'(lat_y[cur]) * GRID_W + int'(lat_x[cur]));

   always_comb begin
      px_x = ORIGIN_X + int'(lat_x[cur]) * TILE + int'(pix) % TILE;
      px_y = ORIGIN_Y + int'(lat_y[cur]) * TILE + int'(pix) / TILE;
   end

   always_ff @(posedge Clk) begin
      if (gr_we)
         grid[gr_waddr] <= gr_wdata;
      if (rd_en)
         rd_data <= grid[cell_idx];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= S_CLEAR;
         cur     <= '0;
         rr_ptr  <= '0;
         pix     <= '0;
         clr_idx <= '0;
         data_q  <= '0;
         wr_held <= 1'b0;
      end else begin
         state   <= state_n;
         cur     <= cur_n;
         rr_ptr  <= rr_n;
         pix     <= pix_n;
         clr_idx <= clr_n;
         data_q  <= data_n;
         wr_held <= wr_held_n;
      end
   end

   always_comb begin
      state_n    = state;
      cur_n      = cur;
      rr_n       = rr_ptr;
      pix_n      = pix;
      clr_n      = clr_idx;
      data_n     = data_q;
      wr_held_n  = wr_held;
      rd_en      = 1'b0;
      gr_we      = 1'b0;
      gr_waddr   = cell_idx;
      gr_wdata   = lat_code[cur];
      set_coll   = 1'b0;
      done       = 1'b0;
      rom_code_o = '0;
      rom_pix_o  = '0;
      fb_addr_o  = '0;
      fb_data_o  = '0;
      fb_we_o    = 1'b0;

      case (state)
         S_IDLE: begin
            if (play && sel_found) begin
               cur_n   = sel;
               state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            rd_en   = !oob;
            state_n = S_MARK;
         end
         S_MARK: begin
            if (oob) begin
               set_coll = 1'b1;
               done     = 1'b1;
               rr_n     = next_rr;
               state_n  = S_IDLE;
            end else begin
               if (rd_data != '0)
                  set_coll = 1'b1;
               gr_we   = 1'b1;
               pix_n   = '0;
               state_n = S_DRAW_RD;
            end
         end
         S_DRAW_RD: begin
            rom_code_o = lat_code[cur];
            rom_pix_o  = pix;
            wr_held_n  = 1'b0;
            state_n    = S_DRAW_WR;
         end
         S_DRAW_WR: begin
            // ROM data is only guaranteed in the first DRAW_WR cycle, so it
            // is captured there and replayed while the frame buffer stalls
            fb_we_o   = 1'b1;
            fb_data_o = wr_held ? data_q : bus.rom_data;
            fb_addr_o = FB_AW'(px_y * FB_W + px_x);
            if (!wr_held) begin
               data_n    = bus.rom_data;
               wr_held_n = 1'b1;
            end
            if (bus.fb_ready) begin
               if (pix == PIX_W'(NPIX-1)) begin
                  done    = 1'b1;
                  rr_n    = next_rr;
                  state_n = S_IDLE;
               end else begin
                  pix_n   = pix + 1'b1;
                  state_n = S_DRAW_RD;
               end
            end
         end
         S_CLEAR: begin
            gr_we    = 1'b1;
            gr_waddr = clr_idx;
            gr_wdata = '0;
            if (clr_idx == GIDX_W'(CELLS-1)) begin
               clr_n   = '0;
               state_n = S_IDLE;
            end else begin
               clr_n = clr_idx + 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // entering play aborts any work; a clear already under way (e.g. just
      // out of reset) carries on since nothing else has touched the grid
      if (entry && state != S_CLEAR) begin
         state_n = S_CLEAR;
         clr_n   = '0;
         gr_we   = 1'b0;
         fb_we_o = 1'b0;
         done    = 1'b0;
      end
   end

   assign bus.rom_code = rom_code_o;
   assign bus.rom_pix  = rom_pix_o;
   assign bus.fb_addr  = fb_addr_o;
   assign bus.fb_data  = fb_data_o;
   assign bus.fb_we    = fb_we_o;

endmodule

// File: tb/tb_trail_engine.sv
// tb/tb_trail_engine.sv - scoreboard bench for trail_engine
module tb_trail_engine;
   localparam int NP = 2, CW = 8, GW = 56, GH = 56, TILE = 8, FBW = 640;
   localparam int OX = 14, OY = 14, FB_AW = 20;
   localparam int CODE_W = $clog2(2*NP+2);
   localparam int PIX_W  = $clog2(TILE*TILE);

   logic                 Clk = 1'b0;
   logic                 Reset_n = 1'b0;
   logic [2:0]           Game_State = 3'd0;
   logic [NP*CW-1:0]     pos_x = '0, pos_y = '0;
   logic [NP*2-1:0]      dir = '0;
   logic [NP-1:0]        collision, overflow;
   logic                 busy;

   trail_engine_if #(.CODE_W(CODE_W), .PIX_W(PIX_W), .FB_AW(FB_AW)) bus();

   trail_engine #(
      .NUM_PLAYERS(NP), .COORD_W(CW), .GRID_W(GW), .GRID_H(GH), .TILE(TILE),
      .FB_W(FBW), .ORIGIN_X(OX), .ORIGIN_Y(OY), .FB_AW(FB_AW), .PLAY_STATE(3'b010)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Game_State(Game_State),
      .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .bus(bus.master),
      .collision(collision), .overflow(overflow), .busy(busy)
   );

   always #5 Clk = ~Clk;

   // sprite ROM: synchronous, content derived from code and pixel index
   always @(posedge Clk)
      bus.rom_data <= 16'((int'(bus.rom_code) << 13) | int'(bus.rom_pix)) ^ 16'hA5C3;

   typedef struct packed { int addr; int data; int pix; } wr_t;
   wr_t exp_q[$];

   int checks = 0, failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- frame-buffer port monitor ----------------
   bit stall_test = 0;
   int stall_cnt  = 0;
   bit held = 0;
   int held_addr, held_data;
   bit grab_first = 0;
   int first_addr = -1;

   always @(negedge Clk) begin
      wr_t e;
      if (!Reset_n) begin
         bus.fb_ready = 1'b0;
         held = 0;
      end else begin
         if (held) begin
            chk("hold_we", int'(bus.fb_we), 1);
            chk("hold_addr", int'(bus.fb_addr), held_addr);
            chk("hold_data", int'(bus.fb_data), held_data);
         end
         if (bus.fb_we && stall_test && exp_q.size() > 0 && exp_q[0].pix == 3 && stall_cnt < 7) begin
            bus.fb_ready = 1'b0;
            stall_cnt++;
         end else begin
            bus.fb_ready = ($urandom_range(0, 3) != 0);
         end
         #1;
         if (bus.fb_we && bus.fb_ready) begin
            held = 0;
            if (exp_q.size() == 0) begin
               chk("unexpected_fb_write", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("fb_addr", int'(bus.fb_addr), e.addr);
               chk("fb_data", int'(bus.fb_data), e.data);
               if (grab_first) begin
                  first_addr = int'(bus.fb_addr);
                  grab_first = 0;
               end
            end
         end else if (bus.fb_we) begin
            held = 1;
            held_addr = int'(bus.fb_addr);
            held_data = int'(bus.fb_data);
         end else begin
            held = 0;
         end
      end
   end

   // ---------------- reference model ----------------
   int mold_x[NP], mold_y[NP], mold_d[NP];
   int in_x[NP], in_y[NP], in_d[NP];
   int mgrid[GW*GH];
   bit mcoll[NP], movf[NP];
   int mrr = 0;

   task automatic drive_inputs();
      for (int p = 0; p < NP; p++) begin
         pos_x[p*CW +: CW] = CW'(in_x[p]);
         pos_y[p*CW +: CW] = CW'(in_y[p]);
         dir[p*2 +: 2]     = 2'(in_d[p]);
      end
   endtask

   function automatic int mcode(input int p, input int d);
      if (d != mold_d[p]) return 2*NP + 1;
      return (d >= 2) ? 1 + 2*p : 2 + 2*p;
   endfunction

   task automatic serve(input int p, input int x, input int y, input int code);
      wr_t e;
      if (x >= GW || y >= GH) begin
         mcoll[p] = 1;
      end else begin
         if (mgrid[y*GW + x] != 0) mcoll[p] = 1;
         mgrid[y*GW + x] = code;
         for (int k = 0; k < TILE*TILE; k++) begin
            e.addr = ((OY + y*TILE + k/TILE) * FBW + OX + x*TILE + k%TILE) & ((1 << FB_AW) - 1);
            e.data = ((code << 13) | k) ^ 16'hA5C3;
            e.pix  = k;
            exp_q.push_back(e);
         end
      end
      mrr = (p + 1) % NP;
   endtask

   function automatic int pack_bits(input bit b0, input bit b1);
      return int'(b0) | (int'(b1) << 1);
   endfunction

   task automatic wait_idle();
      int idle = 0;
      bit ok = 0;
      for (int c = 0; c < 20000 && !ok; c++) begin
         @(negedge Clk);
         if (!busy) idle++; else idle = 0;
         if (idle >= 3) ok = 1;
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_collision"}, int'(collision), pack_bits(mcoll[0], mcoll[1]));
      chk({tag, "_overflow"}, int'(overflow), pack_bits(movf[0], movf[1]));
      chk({tag, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic step(input string tag);
      bit mv[NP];
      int codes[NP];
      for (int p = 0; p < NP; p++) begin
`ifdef COLLIDE_FREEZE_EN
         mv[p] = (in_x[p] != mold_x[p] || in_y[p] != mold_y[p]) && !mcoll[p];
`else
         mv[p] = (in_x[p] != mold_x[p] || in_y[p] != mold_y[p]);
`endif
         codes[p] = mcode(p, in_d[p]);
      end
      begin
         int start = mrr;
         for (int i = 0; i < NP; i++) begin
            int k = (start + i) % NP;
            if (mv[k]) serve(k, in_x[k], in_y[k], codes[k]);
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (in_x[p] != mold_x[p] || in_y[p] != mold_y[p]) begin
            mold_x[p] = in_x[p]; mold_y[p] = in_y[p]; mold_d[p] = in_d[p];
         end
      end
      drive_inputs();
      wait_idle();
      check_flags(tag);
   endtask

   task automatic enter_play_model();
      for (int i = 0; i < GW*GH; i++) mgrid[i] = 0;
      for (int p = 0; p < NP; p++) begin
         mcoll[p] = 0; movf[p] = 0;
         mold_x[p] = in_x[p]; mold_y[p] = in_y[p]; mold_d[p] = in_d[p];
      end
   endtask

   task automatic count_clear(input string tag);
      int cnt = 0;
      for (int c = 0; c < 5000; c++) begin
         if (busy) cnt++;
         else if (cnt > 0) break;
         @(negedge Clk);
      end
      chk({tag, "_busy_cycles"}, cnt, GW*GH);
      chk({tag, "_we_after"}, int'(bus.fb_we), 0);
      chk({tag, "_coll_after"}, int'(collision), 0);
      chk({tag, "_ovf_after"}, int'(overflow), 0);
   endtask

   initial begin
      in_x[0] = 10; in_y[0] = 5;  in_d[0] = 3;
      in_x[1] = 30; in_y[1] = 30; in_d[1] = 0;
      drive_inputs();
      Game_State = 3'b010;
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      chk("reset_collision", int'(collision), 0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_fb_we", int'(bus.fb_we), 0);
      mrr = 0;
      enter_play_model();
      Reset_n = 1'b1;
      count_clear("reset_clear");

      // straight move right, with a 7-cycle stall on pixel 3
      stall_test = 1; stall_cnt = 0; grab_first = 1;
      in_x[0] = 11; in_y[0] = 5; in_d[0] = 3;
      step("move_right");
      chk("first_fb_addr", first_addr, 34662);
      chk("stall_applied", stall_cnt, 7);
      stall_test = 0;

      // turn up: corner sprite
      in_x[0] = 11; in_y[0] = 4; in_d[0] = 0;
      step("corner");

      // P1 runs into the cell P0 just marked
      in_x[1] = 11; in_y[1] = 4; in_d[1] = 2;
      step("p1_hits_p0");

      // two moves during one draw: second one is lost
      in_x[0] = 12; in_y[0] = 4; in_d[0] = 3;
      serve(0, 12, 4, mcode(0, 3));
      mold_x[0] = 12; mold_y[0] = 4; mold_d[0] = 3;
      drive_inputs();
      repeat (10) @(negedge Clk);
      in_x[0] = 13;
      mold_x[0] = 13;
      movf[0] = 1;
      drive_inputs();
      wait_idle();
      check_flags("overflow");

      // off the right edge
      in_x[0] = GW; in_y[0] = 4;
      step("out_of_bounds");

      // simultaneous moves, serviced round-robin
      in_x[0] = 20; in_y[0] = 20; in_d[0] = 1;
      in_x[1] = 21; in_y[1] = 20; in_d[1] = 3;
      step("simultaneous");

      // random walks
      for (int s = 0; s < 40; s++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 1) == 1) begin
               int d = $urandom_range(0, 3);
               int nx = in_x[p], ny = in_y[p];
               case (d)
                  0: ny = ny - 1;
                  1: ny = ny + 1;
                  2: nx = nx - 1;
                  default: nx = nx + 1;
               endcase
               if (nx >= 0 && ny >= 0 && nx <= GW && ny <= GH) begin
                  in_x[p] = nx; in_y[p] = ny; in_d[p] = d;
               end
            end
         end
         step("random");
      end

      // leave and re-enter play: grid and flags cleared
      Game_State = 3'd0;
      repeat (5) @(negedge Clk);
      Game_State = 3'b010;
      enter_play_model();
      count_clear("reentry");

      in_x[0] = 20; in_y[0] = 20; in_d[0] = 1;
      in_x[1] = in_x[1] == 20 && in_y[1] == 19 ? 21 : 20;
      in_y[1] = 19;
      step("after_reentry");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
